corr_win_accum: RTL and testbench

//  Parametrised per-window correlation accumulator for the double-eye distance pipeline. Accumulates
//  sum(g), sum(g^2) and sum(f*g) over NWIN consecutive pixel windows. Squares and products are

---
 rtl/corr_pkg.sv | 15 +
 rtl/corr_acc_lane.sv | 65 ++++++
 rtl/corr_win_accum.sv | 140 ++++++++++++++
 tb/tb_corr_win_accum.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared types and width helpers for the per-window correlation accumulator.
package corr_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} corr_state_t;

    // Sample-count width; sums gain this many bits over a single term.
    function automatic int sw_of(input int max_samp);
        return $clog2(max_samp + 1);
    endfunction

    function automatic int acc_w(input int term_w, input int max_samp);
        return term_w + sw_of(max_samp);
    endfunction

endpackage

// File: rtl/corr_acc_lane.sv
// One window's accumulator set and sample count; sum(f)/sum(f*f) exist only with CORR_FSUM_EN.
module corr_acc_lane
    import corr_pkg::*;
#(
    parameter int FW       = 3,
    parameter int GW       = 3,
    parameter int MAX_SAMP = 256,
    localparam int SW      = sw_of(MAX_SAMP)
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  en,
    input  logic [FW-1:0]         f,
    input  logic [GW-1:0]         g,
    output logic [GW+SW-1:0]      gsum,
    output logic [2*GW+SW-1:0]    g2sum,
    output logic [FW+GW+SW-1:0]   fgsum,
`ifdef CORR_FSUM_EN
    output logic [FW+SW-1:0]      fsum,
    output logic [2*FW+SW-1:0]    f2sum,
`endif
    output logic                  ovf
);

    logic [SW-1:0]       cnt;
    logic                full;
    logic                take;
    logic [2*GW-1:0]     g2;
    logic [FW+GW-1:0]    fg;

    assign full = (cnt == SW'(MAX_SAMP));
    assign take = en && !full;
    assign ovf  = en && full;
    // Widen before multiplying so the product keeps its full width.
    assign g2   = (2*GW)'(g) * (2*GW)'(g);
    assign fg   = (FW+GW)'(f) * (FW+GW)'(g);

`ifdef CORR_FSUM_EN
    logic [2*FW-1:0] f2;
    assign f2 = (2*FW)'(f) * (2*FW)'(f);
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt   <= '0;
            gsum  <= '0;
            g2sum <= '0;
            fgsum <= '0;
`ifdef CORR_FSUM_EN
            fsum  <= '0;
            f2sum <= '0;
`endif
        end else if (take) begin
            cnt   <= cnt + 1'b1;
            gsum  <= gsum + (GW+SW)'(g);
            g2sum <= g2sum + (2*GW+SW)'(g2);
            fgsum <= fgsum + (FW+GW+SW)'(fg);
`ifdef CORR_FSUM_EN
            fsum  <= fsum + (FW+SW)'(f);
            f2sum <= f2sum + (2*FW+SW)'(f2);
`endif
        end
    end

endmodule

// File: rtl/corr_win_accum.sv
// Per-window correlation accumulator: FSM, window pointer, drain index, place tags, output mux.
// Optional sum(f)/sum(f*f) outputs are enabled with CORR_FSUM_EN.
module corr_win_accum
    import corr_pkg::*;
#(
    parameter int NWIN       = 4,
    parameter int FW         = 3,
    parameter int GW         = 3,
    parameter int MAX_SAMP   = 256,
    parameter int PLACE_W    = 6,
    parameter int PLACE_STEP = 16,
    localparam int SW        = sw_of(MAX_SAMP)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_adv,
    input  logic [FW-1:0]         fdata,
    input  logic [GW-1:0]         gdata,
    input  logic                  flush,
    input  logic [PLACE_W-1:0]    startplace,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [GW+SW-1:0]      out_gsum,
    output logic [2*GW+SW-1:0]    out_g2sum,
    output logic [FW+GW+SW-1:0]   out_fgsum,
`ifdef CORR_FSUM_EN
    output logic [FW+SW-1:0]      out_fsum,
    output logic [2*FW+SW-1:0]    out_f2sum,
`endif
    output logic [PLACE_W-1:0]    out_place,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_ovf
);

    localparam int PW = $clog2(NWIN + 1);
    localparam int KW = $clog2(NWIN);
    localparam logic [PW-1:0] PTR_FULL = PW'(NWIN);
    localparam logic [KW-1:0] K_LAST   = KW'(NWIN - 1);

    corr_state_t   state;
    logic [PW-1:0] ptr;
    logic [KW-1:0] k;
    logic [PLACE_W-1:0] place;
    logic          fire;
    logic          clear;

    logic [NWIN-1:0]                 lane_en;
    logic [NWIN-1:0]                 lane_ovf;
    logic [NWIN-1:0][GW+SW-1:0]      lane_gsum;
    logic [NWIN-1:0][2*GW+SW-1:0]    lane_g2sum;
    logic [NWIN-1:0][FW+GW+SW-1:0]   lane_fgsum;
`ifdef CORR_FSUM_EN
    logic [NWIN-1:0][FW+SW-1:0]      lane_fsum;
    logic [NWIN-1:0][2*FW+SW-1:0]    lane_f2sum;
`endif

    assign in_ready = (state == ACCUM) && (ptr < PTR_FULL);
    assign fire     = in_valid && in_ready && !start;
    assign clear    = rst || start;
    assign busy     = (state != IDLE);

    for (genvar i = 0; i < NWIN; i++) begin : g_lane
        assign lane_en[i] = fire && (ptr == PW'(i));
        corr_acc_lane #(.FW(FW), .GW(GW), .MAX_SAMP(MAX_SAMP)) u_lane (
            .clk   (clk),
            .clear (clear),
            .en    (lane_en[i]),
            .f     (fdata),
            .g     (gdata),
            .gsum  (lane_gsum[i]),
            .g2sum (lane_g2sum[i]),
            .fgsum (lane_fgsum[i]),
`ifdef CORR_FSUM_EN
            .fsum  (lane_fsum[i]),
            .f2sum (lane_f2sum[i]),
`endif
            .ovf   (lane_ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            k         <= '0;
            place     <= '0;
            out_valid <= 1'b0;
            err_ovf   <= 1'b0;
        end else if (start) begin
            state     <= ACCUM;
            ptr       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (|lane_ovf)
                        err_ovf <= 1'b1;
                    if (in_adv && ptr < PTR_FULL)
                        ptr <= ptr + 1'b1;
                    if (flush) begin
                        state     <= DRAIN;
                        k         <= '0;
                        place     <= startplace;
                        out_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Back-to-back handshakes move one window per cycle.
                    if (out_valid && out_ready) begin
                        if (k == K_LAST) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            k     <= k + 1'b1;
                            place <= place + PLACE_W'(PLACE_STEP);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_gsum  = out_valid ? lane_gsum[k]  : '0;
    assign out_g2sum = out_valid ? lane_g2sum[k] : '0;
    assign out_fgsum = out_valid ? lane_fgsum[k] : '0;
`ifdef CORR_FSUM_EN
    assign out_fsum  = out_valid ? lane_fsum[k]  : '0;
    assign out_f2sum = out_valid ? lane_f2sum[k] : '0;
`endif
    assign out_place = out_valid ? place : '0;
    assign out_last  = out_valid && (k == K_LAST);

endmodule

// File: tb/tb_corr_win_accum.sv
// Directed bench for corr_win_accum (NWIN=4, FW=GW=3, MAX_SAMP=4, PLACE_W=6, PLACE_STEP=16).
module tb_corr_win_accum;

    localparam int NWIN = 4, FW = 3, GW = 3, MAX_SAMP = 4, PLACE_W = 6, PLACE_STEP = 16;
    localparam int SW = $clog2(MAX_SAMP + 1);

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, in_adv, flush, out_valid, out_ready;
    logic out_last, busy, err_ovf;
    logic [FW-1:0]        fdata;
    logic [GW-1:0]        gdata;
    logic [PLACE_W-1:0]   startplace, out_place;
    logic [GW+SW-1:0]     out_gsum;
    logic [2*GW+SW-1:0]   out_g2sum;
    logic [FW+GW+SW-1:0]  out_fgsum;
`ifdef CORR_FSUM_EN
    logic [FW+SW-1:0]     out_fsum;
    logic [2*FW+SW-1:0]   out_f2sum;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    corr_win_accum #(
        .NWIN(NWIN), .FW(FW), .GW(GW), .MAX_SAMP(MAX_SAMP),
        .PLACE_W(PLACE_W), .PLACE_STEP(PLACE_STEP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_adv(in_adv), .fdata(fdata), .gdata(gdata), .flush(flush),
        .startplace(startplace), .out_valid(out_valid), .out_ready(out_ready),
        .out_gsum(out_gsum), .out_g2sum(out_g2sum), .out_fgsum(out_fgsum),
`ifdef CORR_FSUM_EN
        .out_fsum(out_fsum), .out_f2sum(out_f2sum),
`endif
        .out_place(out_place), .out_last(out_last), .busy(busy), .err_ovf(err_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_win(input string tag, input int g, input int g2, input int fg,
                           input int pl, input int last);
        chk({tag, ".valid"}, 32'(out_valid), 1);
        chk({tag, ".gsum"},  32'(out_gsum),  g);
        chk({tag, ".g2sum"}, 32'(out_g2sum), g2);
        chk({tag, ".fgsum"}, 32'(out_fgsum), fg);
        chk({tag, ".place"}, 32'(out_place), pl);
        chk({tag, ".last"},  32'(out_last),  last);
    endtask

    task automatic sample(input int f, input int g, input logic adv);
        in_valid = 1'b1;
        fdata    = FW'(f);
        gdata    = GW'(g);
        in_adv   = adv;
    endtask

    // Frame used by scenarios 2 and 3: (2,3),(1,7)+adv into k0, (7,7) into k1 with flush.
    task automatic load_frame();
        start = 1'b1; tick(); start = 1'b0;
        chk("frame.busy", 32'(busy), 1);
        chk("frame.in_ready", 32'(in_ready), 1);
        sample(2, 3, 1'b0); tick();
        sample(1, 7, 1'b1); tick();
        sample(7, 7, 1'b0);
        flush = 1'b1; startplace = 6'd5; tick();
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_adv = 1'b0; flush = 1'b0;
        out_ready = 1'b0; fdata = '0; gdata = '0; startplace = '0;

        // 1: reset state, flush ignored in IDLE
        tick(); tick();
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.in_ready", 32'(in_ready), 0);
        chk("rst.err_ovf", 32'(err_ovf), 0);
        chk("rst.gsum", 32'(out_gsum), 0);
        chk("rst.place", 32'(out_place), 0);
        chk("rst.last", 32'(out_last), 0);
        rst = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0; tick();
        chk("idle_flush.out_valid", 32'(out_valid), 0);
        chk("idle_flush.busy", 32'(busy), 0);

        // 2: basic frame, free-running drain
        out_ready = 1'b1;
        load_frame();
        chk_win("t2.k0", 10, 58, 13, 5, 0);  tick();
        chk_win("t2.k1", 7, 49, 49, 21, 0);  tick();
        chk_win("t2.k2", 0, 0, 0, 37, 0);    tick();
        chk_win("t2.k3", 0, 0, 0, 53, 1);    tick();
        chk("t2.end.valid", 32'(out_valid), 0);
        chk("t2.end.busy", 32'(busy), 0);

        // 3: backpressure mid-drain holds window 1 stable
        load_frame();
        chk_win("t3.k0", 10, 58, 13, 5, 0);  tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_win("t3.hold", 7, 49, 49, 21, 0);
        end
        out_ready = 1'b1; tick();
        chk_win("t3.k2", 0, 0, 0, 37, 0);    tick();
        chk_win("t3.k3", 0, 0, 0, 53, 1);    tick();
        chk("t3.end.valid", 32'(out_valid), 0);
        chk("t3.end.busy", 32'(busy), 0);

        // 4: overflow at MAX_SAMP, cleared by the next start
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample(1, 1, 1'b0); tick();
        end
        chk("t4.err_before", 32'(err_ovf), 0);
        tick();
        in_valid = 1'b0;
        chk("t4.err_after", 32'(err_ovf), 1);
        flush = 1'b1; startplace = 6'd0; tick(); flush = 1'b0;
        chk_win("t4.k0", 4, 4, 4, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t4.err_cleared", 32'(err_ovf), 0);
        chk("t4.abort.valid", 32'(out_valid), 0);

        // 5: frame full after NWIN advances; further samples refused; place wraps
        in_adv = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t5.in_ready", 32'(in_ready), 0);
        sample(7, 7, 1'b1); tick();
        in_valid = 1'b0; in_adv = 1'b0;
        chk("t5.busy", 32'(busy), 1);
        flush = 1'b1; startplace = 6'd56; tick(); flush = 1'b0;
        chk_win("t5.k0", 0, 0, 0, 56, 0);    tick();
        chk_win("t5.k1", 0, 0, 0, 8, 0);     tick();
        chk_win("t5.k2", 0, 0, 0, 24, 0);    tick();
        chk_win("t5.k3", 0, 0, 0, 40, 1);    tick();
        chk("t5.end.valid", 32'(out_valid), 0);

        // 6: start during drain at k=1 aborts and clears sums
        start = 1'b1; tick(); start = 1'b0;
        sample(2, 3, 1'b1); tick();
        sample(5, 6, 1'b0);
        flush = 1'b1; startplace = 6'd5; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk_win("t6.k0", 3, 9, 6, 5, 0);     tick();
        chk_win("t6.k1", 6, 36, 30, 21, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t6.abort.valid", 32'(out_valid), 0);
        chk("t6.abort.busy", 32'(busy), 1);
        chk("t6.abort.in_ready", 32'(in_ready), 1);
        flush = 1'b1; startplace = 6'd0; tick(); flush = 1'b0;
        chk_win("t6.clr.k0", 0, 0, 0, 0, 0); tick();
        chk_win("t6.clr.k1", 0, 0, 0, 16, 0); tick(); tick(); tick();
        chk("t6.end.busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
